// File: rtl/io_responder.sv
// Memory-mapped I/O responder: LED register, synchronized switches,
// debounced pushbuttons and a write-1-to-clear key press-capture register.
module io_responder #(
  parameter logic [31:0] LED_ADDR  = 32'h0000_000F,
  parameter logic [31:0] SW_ADDR   = 32'h0000_0010,
  parameter logic [31:0] KEY_ADDR  = 32'h0000_0011,
  parameter logic [31:0] EDGE_ADDR = 32'h0000_0012,
  parameter logic [19:0] DB_CYCLES = 20'd500000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] realaddr,
  input  logic [31:0] dout,
  input  logic        W,
  output logic [31:0] din,
  output logic        io_hit,
  input  logic [9:0]  SW,
  input  logic [3:0]  KEY,
  output logic [9:0]  LEDR
);

  logic [9:0]  sw_meta;
  logic [9:0]  sw_sync;
  logic [3:0]  key_meta;
  logic [3:0]  key_sync;
  logic [3:0]  key_db;
  logic [3:0]  key_edge;
  logic [19:0] cnt [4];

  logic        hit_led;
  logic        hit_sw;
  logic        hit_key;
  logic        hit_edge;
  logic        hit_any;
  logic [31:0] rd_data;
  logic [3:0]  db_flip;
  logic [3:0]  press;
  logic [3:0]  edge_clr;

  logic        unused_dout;
  assign unused_dout = ^dout[31:10];

  // Address decode and read mux operate on pre-edge register values, so a
  // read always sees the state before any same-edge write or capture.
  always_comb begin
    hit_led  = (realaddr == LED_ADDR);
    hit_sw   = (realaddr == SW_ADDR);
    hit_key  = (realaddr == KEY_ADDR);
    hit_edge = (realaddr == EDGE_ADDR);
    hit_any  = hit_led | hit_sw | hit_key | hit_edge;
    rd_data  = '0;
    if (hit_led) begin
      rd_data = {22'b0, LEDR};
    end else if (hit_sw) begin
      rd_data = {22'b0, sw_sync};
    end else if (hit_key) begin
      rd_data = {28'b0, key_db};
    end else if (hit_edge) begin
      rd_data = {28'b0, key_edge};
    end
  end

  // A debounced level flips when the disagreement has lasted the full
  // window; a press is such a flip from released (1) to pressed (0).
  always_comb begin
    db_flip = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      db_flip[i] = (key_sync[i] != key_db[i]) && (cnt[i] == DB_CYCLES - 20'd1);
    end
    press    = db_flip & key_db;
    edge_clr = (W && hit_edge) ? dout[3:0] : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      key_meta <= '1;
      key_sync <= '1;
    end else begin
      sw_meta  <= SW;
      sw_sync  <= sw_meta;
      key_meta <= KEY;
      key_sync <= key_meta;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_db <= '1;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (key_sync[i] == key_db[i]) begin
          cnt[i] <= '0;
        end else if (db_flip[i]) begin
          key_db[i] <= key_sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 20'd1;
        end
      end
    end
  end

  // Set has priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_edge <= '0;
    end else begin
      key_edge <= (key_edge & ~edge_clr) | press;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      LEDR <= '0;
    end else if (W && hit_led) begin
      LEDR <= dout[9:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      din    <= '0;
      io_hit <= 1'b0;
    end else begin
      din    <= rd_data;
      io_hit <= hit_any;
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// Testbench for io_responder: directed vector table, hand-written debounce
// and reset sequences, then randomized traffic against a behavioural model.
module tb_io_responder;

  localparam logic [31:0] A_LED  = 32'h0000_000F;
  localparam logic [31:0] A_SW   = 32'h0000_0010;
  localparam logic [31:0] A_KEY  = 32'h0000_0011;
  localparam logic [31:0] A_EDGE = 32'h0000_0012;
  localparam int          DB     = 4;

  logic        clk;
  logic        resetn;
  logic [31:0] realaddr;
  logic [31:0] dout;
  logic        W;
  logic [31:0] din;
  logic        io_hit;
  logic [9:0]  SW;
  logic [3:0]  KEY;
  logic [9:0]  LEDR;

  int checks = 0;
  int errors = 0;

  io_responder #(
    .LED_ADDR (A_LED),
    .SW_ADDR  (A_SW),
    .KEY_ADDR (A_KEY),
    .EDGE_ADDR(A_EDGE),
    .DB_CYCLES(20'd4)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .realaddr(realaddr),
    .dout    (dout),
    .W       (W),
    .din     (din),
    .io_hit  (io_hit),
    .SW      (SW),
    .KEY     (KEY),
    .LEDR    (LEDR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Behavioural model: sync pipes as two-entry histories, debounce as a
  // run length of consecutive disagreeing cycles.
  logic [9:0]  m_led;
  logic [9:0]  m_sw_hist [2];
  logic [3:0]  m_key_hist [2];
  logic [3:0]  m_db;
  int          m_run [4];
  logic [3:0]  m_edge;
  logic [31:0] m_din;
  logic        m_hit;

  task automatic model_reset();
    m_led = '0;
    m_sw_hist[0] = '0;  m_sw_hist[1] = '0;
    m_key_hist[0] = '1; m_key_hist[1] = '1;
    m_db = '1;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_edge = '0;
    m_din = '0;
    m_hit = 1'b0;
  endtask

  task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic w,
                            input logic [9:0] sw, input logic [3:0] key);
    logic [3:0] set_bits;
    m_hit = 1'b1;
    if (a == A_LED)       m_din = {22'b0, m_led};
    else if (a == A_SW)   m_din = {22'b0, m_sw_hist[1]};
    else if (a == A_KEY)  m_din = {28'b0, m_db};
    else if (a == A_EDGE) m_din = {28'b0, m_edge};
    else begin
      m_din = '0;
      m_hit = 1'b0;
    end
    set_bits = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_key_hist[1][i] == m_db[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DB) begin
          m_db[i] = m_key_hist[1][i];
          m_run[i] = 0;
          if (!m_db[i]) set_bits[i] = 1'b1;
        end
      end
    end
    if (w && a == A_EDGE) m_edge = m_edge & ~d[3:0];
    m_edge = m_edge | set_bits;
    if (w && a == A_LED) m_led = d[9:0];
    m_sw_hist[1]  = m_sw_hist[0];
    m_sw_hist[0]  = sw;
    m_key_hist[1] = m_key_hist[0];
    m_key_hist[0] = key;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w);
    realaddr = a;
    dout     = d;
    W        = w;
    model_edge(a, d, w, SW, KEY);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(32'h0, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    cyc(a, 32'h0, 1'b0);
    chk(nm, din, exp);
    chk({nm, "_hit"}, {31'b0, io_hit}, 32'h1);
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    W        = 1'b0;
    realaddr = '0;
    dout     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_din", din, 32'h0);
    chk("rst_hit", {31'b0, io_hit}, 32'h0);
    chk("rst_led", {22'b0, LEDR}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        w;
    logic [31:0] exp_din;
    logic        exp_hit;
    logic [9:0]  exp_led;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{32'h0F, 32'h0000_03A5, 1'b1, 32'h000, 1'b1, 10'h3A5};
    tbl[1]  = '{32'h0F, 32'h0000_0000, 1'b0, 32'h3A5, 1'b1, 10'h3A5};
    tbl[2]  = '{32'h20, 32'h0000_0000, 1'b0, 32'h000, 1'b0, 10'h3A5};
    tbl[3]  = '{32'h10, 32'h0000_0000, 1'b0, 32'h2C1, 1'b1, 10'h3A5};
    tbl[4]  = '{32'h11, 32'h0000_0000, 1'b0, 32'h00F, 1'b1, 10'h3A5};
    tbl[5]  = '{32'h12, 32'h0000_0000, 1'b0, 32'h000, 1'b1, 10'h3A5};
    tbl[6]  = '{32'h10, 32'hFFFF_FFFF, 1'b1, 32'h2C1, 1'b1, 10'h3A5};
    tbl[7]  = '{32'h20, 32'h0000_0155, 1'b1, 32'h000, 1'b0, 10'h3A5};
    tbl[8]  = '{32'h11, 32'h0000_0000, 1'b1, 32'h00F, 1'b1, 10'h3A5};
    tbl[9]  = '{32'h0F, 32'h0000_0000, 1'b0, 32'h3A5, 1'b1, 10'h3A5};
    tbl[10] = '{32'h0F, 32'hFFFF_FC00, 1'b1, 32'h3A5, 1'b1, 10'h000};
    tbl[11] = '{32'h0F, 32'h0000_0000, 1'b0, 32'h000, 1'b1, 10'h000};

    SW  = 10'h2C1;
    KEY = 4'hF;
    do_reset();

    for (int v = 0; v < 12; v++) begin
      cyc(tbl[v].addr, tbl[v].wdata, tbl[v].w);
      chk($sformatf("vec%0d_din", v), din, tbl[v].exp_din);
      chk($sformatf("vec%0d_hit", v), {31'b0, io_hit}, {31'b0, tbl[v].exp_hit});
      chk($sformatf("vec%0d_led", v), {22'b0, LEDR}, {22'b0, tbl[v].exp_led});
    end

    // Three-cycle glitch on KEY[2] must be filtered.
    KEY = 4'hB;
    for (int k = 0; k < 3; k++) rd(A_KEY, 32'hF, "glitch_key_during");
    KEY = 4'hF;
    idle(8);
    rd(A_KEY, 32'hF, "glitch_key_after");
    rd(A_EDGE, 32'h0, "glitch_edge");

    // Eight-cycle press: level and capture both register it.
    KEY = 4'hB;
    idle(8);
    rd(A_KEY, 32'hB, "press_key");
    rd(A_EDGE, 32'h4, "press_edge");
    KEY = 4'hF;
    idle(8);
    rd(A_KEY, 32'hF, "release_key");
    rd(A_EDGE, 32'h4, "release_edge_held");

    // Clear on the same edge a new press lands: set wins.
    KEY = 4'hB;
    idle(5);
    cyc(A_EDGE, 32'h4, 1'b1);
    chk("setclr_din", din, 32'h4);
    rd(A_EDGE, 32'h4, "setclr_edge");
    rd(A_KEY, 32'hB, "setclr_key");
    KEY = 4'hF;
    idle(8);
    cyc(A_EDGE, 32'h4, 1'b1);
    chk("clr_din", din, 32'h4);
    rd(A_EDGE, 32'h0, "clr_edge");

    // Mid-operation asynchronous reset.
    KEY = 4'h0;
    idle(8);
    KEY = 4'hF;
    idle(8);
    cyc(A_LED, 32'h3FF, 1'b1);
    KEY = 4'hE;
    idle(3);
    rd(A_EDGE, 32'hF, "pre_rst_edge");
    chk("pre_rst_led", {22'b0, LEDR}, 32'h3FF);
    #1;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("async_rst_din", din, 32'h0);
    chk("async_rst_hit", {31'b0, io_hit}, 32'h0);
    chk("async_rst_led", {22'b0, LEDR}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) rd(A_EDGE, 32'h0, $sformatf("post_rst_edge%0d", k));
    rd(A_EDGE, 32'h1, "post_rst_edge_set");
    rd(A_KEY, 32'hE, "post_rst_key");
    chk("post_rst_led", {22'b0, LEDR}, 32'h0);

    // Randomized traffic against the model.
    KEY = 4'hF;
    SW  = 10'($urandom);
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      int          sel;
      if ($urandom_range(0, 15) == 0) SW = 10'($urandom);
      if ($urandom_range(0, 11) == 0) KEY[$urandom_range(0, 3)] ^= 1'b1;
      sel = int'($urandom_range(0, 6));
      case (sel)
        0: a = A_LED;
        1: a = A_SW;
        2: a = A_KEY;
        3, 4: a = A_EDGE;
        5: a = $urandom;
        default: a = ($urandom_range(0, 1) == 0) ? 32'h0000_000E : 32'h0000_0013;
      endcase
      cyc(a, $urandom, ($urandom_range(0, 2) == 0));
      chk("rnd_din", din, m_din);
      chk("rnd_hit", {31'b0, io_hit}, {31'b0, m_hit});
      chk("rnd_led", {22'b0, LEDR}, {22'b0, m_led});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter LED_ADDR, default 32'h0000_000F: word address of the LED output register (read/write).
REQ-002 Parameter SW_ADDR, default 32'h0000_0010: word address of the synchronized switch register (read-only).
REQ-003 Parameter KEY_ADDR, default 32'h0000_0011: word address of the debounced key level register (read-only).
REQ-004 Parameter EDGE_ADDR, default 32'h0000_0012: word address of the key press-capture register (read, write-1-to-clear).
REQ-005 Parameter DB_CYCLES, default 20'd500000: debounce stability window in clk cycles (10 ms at 50 MHz); legal range 1..2^20-1.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 realaddr  input  32  processor bus word address.
REQ-009 dout  input  32  processor write data.
REQ-010 W  input  1  processor write strobe, qualified by realaddr.
REQ-011 din  output  32  registered read data to processor.
REQ-012 io_hit  output  1  registered flag: din is valid I/O data this cycle (system mux selects din over RAM q).
REQ-013 SW  input  10  asynchronous slide switches.
REQ-014 KEY  input  4  asynchronous pushbuttons, active-low (0 = pressed).
REQ-015 LEDR  output  10  LED register contents.

Function
REQ-016 Bus timing SHALL match the synchronous RAM: address sampled at edge N, din/io_hit valid after edge N (one-cycle read latency); no read strobe, a read occurs every cycle.
REQ-017 At each edge, io_hit SHALL load 1 if realaddr equals any of the four mapped addresses, else 0; din SHALL load the selected register value, or 32'h0 when unmapped.
REQ-018 Read data SHALL be zero-extended: LED -> {22'b0, LEDR}; SW -> {22'b0, sw_sync}; KEY -> {28'b0, key_db}; EDGE -> {28'b0, edge}.
REQ-019 A read SHALL return the register value before any same-edge write or capture (read-before-write).
REQ-020 W=1 with realaddr==LED_ADDR SHALL load LEDR <= dout[9:0]; W to SW_ADDR or KEY_ADDR SHALL be ignored; W to unmapped addresses SHALL have no effect.
REQ-021 SW SHALL pass through a 2-flop synchronizer; sw_sync is the second stage (2-cycle latency, no debounce).
REQ-022 KEY SHALL pass through a 2-flop synchronizer; each bit i SHALL then have an independent debouncer with a 20-bit counter cnt[i] and stable state key_db[i].
REQ-023 Debouncer: if key_sync[i]==key_db[i], cnt[i] <= 0; else cnt[i] <= cnt[i]+1, and when cnt[i]==DB_CYCLES-1, key_db[i] <= key_sync[i] and cnt[i] <= 0.
REQ-024 A glitch shorter than DB_CYCLES consecutive cycles SHALL NOT change key_db; cnt SHALL NOT wrap.
REQ-025 edge[i] SHALL set when key_db[i] transitions 1->0 (press); release SHALL NOT set it.
REQ-026 W=1 with realaddr==EDGE_ADDR SHALL clear each edge[i] where dout[i]==1; dout[31:4] ignored.
REQ-027 Simultaneous set and clear of the same edge bit SHALL leave it set (set wins).
REQ-028 edge bits SHALL hold until explicitly cleared; repeated presses while set SHALL leave the bit at 1.

Reset
REQ-029 resetn=0 SHALL asynchronously force: din=0, io_hit=0, LEDR=0, edge=0, all cnt=0, SW sync flops=0, KEY sync flops=4'hF, key_db=4'hF.
REQ-030 Reset asserted mid-debounce SHALL discard the count; after release, debounce restarts from 0 with key_db=4'hF, and no edge is captured from reset release.
REQ-031 First edge after resetn rises SHALL behave as a normal cycle (no extra wait states).

Verification (DB_CYCLES=4 in bench)
REQ-032 W=1, realaddr=0xF, dout=32'h0000_03A5; next cycle read 0xF -> LEDR=10'h3A5, following cycle din=32'h3A5, io_hit=1.
REQ-033 SW=10'h2C1 held; read 0x10 three cycles later -> din=32'h2C1; read 0x20 -> din=0, io_hit=0.
REQ-034 KEY[2] low for 3 cycles then high -> key_db stays 4'hF, edge=0; KEY[2] low for 8 cycles -> key_db=4'hB, read 0x12 -> din=32'h4.
REQ-035 edge=4'h4; write 0x12 dout=32'h4 on the same edge key_db[2] falls again -> edge stays 4'h4; write again with no press -> edge=0.
REQ-036 Assert resetn=0 mid-operation with LEDR=10'h3FF, edge=4'hF, KEY[0] mid-count -> all outputs 0 immediately; after release, KEY[0] must be held low 4+ cycles before edge[0] sets.
